// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between an
// instruction-fetch requester and a data requester with round-robin tie-break.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_c, grant_data_c;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              busy_q, busy_d;
    logic              mem_we_q, mem_we_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;

    // State register; reset abandons any in-flight access immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant decision; requests are only looked at in IDLE
    always_comb begin
        state_d      = state_q;
        grant_c      = 1'b0;
        grant_data_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_c      = 1'b1;
                    grant_data_c = (i_req && d_req) ? ~last_grant_q : d_req;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        busy_d   = (state_d != IDLE);
        mem_we_d = grant_c && grant_data_c && d_we;
        i_done_d = (state_d == RESP) && !owner_q;
        d_done_d = (state_d == RESP) && owner_q;
    end

    // Registered control outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            mem_we_q <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            mem_we_q <= mem_we_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    // Datapath next-state: request capture on grant, latency count, read-data capture
    always_comb begin
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        if (grant_c) begin
            owner_d = grant_data_c;
            we_d    = grant_data_c && d_we;
            addr_d  = grant_data_c ? d_addr : i_addr;
            wdata_d = grant_data_c ? d_wdata : '0;
            cnt_d   = CNT_LOAD;
        end
        if (state_q == ACCESS) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (!we_q) begin
                if (owner_q) begin
                    d_rdata_d = mem_rdata;
                end else begin
                    i_rdata_d = mem_rdata;
                end
            end
        end
        if (state_q == RESP) begin
            last_grant_d = owner_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the two-port memory arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // LAT=2 instance
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          owner;

    // LAT=1 instance
    logic          l1_i_req = 1'b0;
    logic [AW-1:0] l1_i_addr = '0;
    logic [DW-1:0] l1_i_rdata;
    logic          l1_i_done;
    logic          l1_d_req = 1'b0;
    logic          l1_d_we = 1'b0;
    logic [AW-1:0] l1_d_addr = '0;
    logic [DW-1:0] l1_d_wdata = '0;
    logic [DW-1:0] l1_d_rdata;
    logic          l1_d_done;
    logic [AW-1:0] l1_mem_addr;
    logic [DW-1:0] l1_mem_wdata;
    logic          l1_mem_we;
    logic [DW-1:0] l1_mem_rdata;
    logic          l1_busy;
    logic          l1_owner;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_rdata(l1_i_rdata), .i_done(l1_i_done),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_rdata(l1_d_rdata), .d_done(l1_d_done),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_we(l1_mem_we),
        .mem_rdata(l1_mem_rdata), .busy(l1_busy), .owner(l1_owner)
    );

    // Memory contents: fixed pattern per address, one stored word overrides it
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        if (a == 64'h40) return 64'h0000_0000_0050_0093;
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [DW-1:0] wr_data  = '0;

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (wr_valid && wr_addr == a) return wr_data;
        return pat(a);
    endfunction

    // LAT=2 memory: read data appears one edge after the address is presented,
    // so it is valid on the second edge after the grant
    always @(posedge clk) begin
        mem_rdata <= mem_read(mem_addr);
        if (mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
    end

    // LAT=1 memory: combinational read
    assign l1_mem_rdata = pat(l1_mem_addr);

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_i = '0;
    logic [DW-1:0] exp_d = '0;
    exp_t          mon_e;
    logic [DW-1:0] mon_obs;

    // Completion monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!reset && (i_done || d_done)) begin
            n_tests++;
            if (i_done && d_done) begin
                n_fail++;
                $display("FAIL done_overlap: i_done=%b d_done=%b, required at most one high", i_done, d_done);
            end
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: i_done=%b d_done=%b, required no completion", i_done, d_done);
            end else begin
                mon_e   = sb_q.pop_front();
                mon_obs = d_done ? d_rdata : i_rdata;
                if (d_done !== mon_e.port || mon_obs !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL sb_completion: port=%b rdata=%h, required port=%b rdata=%h",
                             d_done, mon_obs, mon_e.port, mon_e.data);
                end
            end
        end
    end

    task automatic expect_txn(input logic port, input logic [DW-1:0] data);
        sb_q.push_back('{port: port, data: data});
        if (port) exp_d = data;
        else      exp_i = data;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        i_req    = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        l1_d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sb_q.delete();
        exp_i = '0;
        exp_d = '0;
    endtask

    task automatic test_reset();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                @(posedge clk);
                #1 reset = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if ({busy, mem_we, i_done, d_done, owner, l1_busy} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl ph%0d: busy,we,idone,ddone,owner,l1busy=%b, required 000000",
                         ph, {busy, mem_we, i_done, d_done, owner, l1_busy});
            end
            n_tests++;
            if (mem_addr !== '0 || mem_wdata !== '0) begin
                n_fail++;
                $display("FAIL reset_mem ph%0d: mem_addr=%h mem_wdata=%h, required 0", ph, mem_addr, mem_wdata);
            end
            n_tests++;
            if (i_rdata !== '0 || d_rdata !== '0) begin
                n_fail++;
                $display("FAIL reset_rdata ph%0d: i_rdata=%h d_rdata=%h, required 0", ph, i_rdata, d_rdata);
            end
        end
    endtask

    task automatic test_fetch();
        int busy_n, we_n, done_n, done_at;
        busy_n = 0; we_n = 0; done_n = 0; done_at = -1;
        @(posedge clk);
        #1;
        i_addr = 64'h40;
        i_req  = 1'b1;
        expect_txn(1'b0, 64'h0000_0000_0050_0093);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (mem_we) we_n++;
            if (i_done) begin
                done_n++;
                done_at = busy_n;
                i_req = 1'b0;
            end
        end
        n_tests++;
        if (busy_n !== 3 || done_at !== 3) begin
            n_fail++;
            $display("FAIL fetch_timing: busy_cycles=%0d done_in_busy_cycle=%0d, required 3 and 3", busy_n, done_at);
        end
        n_tests++;
        if (we_n !== 0 || done_n !== 1) begin
            n_fail++;
            $display("FAIL fetch_strobes: mem_we_cycles=%0d i_done_pulses=%0d, required 0 and 1", we_n, done_n);
        end
        n_tests++;
        if (i_rdata !== 64'h0000_0000_0050_0093 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hold: i_rdata=%h owner=%b, required 500093 and 0", i_rdata, owner);
        end
    endtask

    task automatic test_tie();
        logic [9:0] trace;
        logic [9:0] own;
        trace = '0; own = '0;
        apply_reset();
        i_addr = 64'h48;
        d_addr = 64'h200;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        expect_txn(1'b1, pat(64'h200));
        expect_txn(1'b0, pat(64'h48));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            trace[k] = busy;
            own[k]   = owner;
            if (d_done) d_req = 1'b0;
            if (i_done) i_req = 1'b0;
        end
        n_tests++;
        if (trace !== 10'b0011101110) begin
            n_fail++;
            $display("FAIL tie_busy_trace: %b, required 0011101110", trace);
        end
        n_tests++;
        if (own[1] !== 1'b1 || own[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_order: first_owner=%b second_owner=%b, required 1 then 0", own[1], own[5]);
        end
    endtask

    task automatic test_store();
        int            we_n, done_n;
        logic [AW-1:0] we_addr;
        logic [DW-1:0] we_data;
        logic [DW-1:0] prev_d;
        we_n = 0; done_n = 0; we_addr = '0; we_data = '0;
        prev_d = exp_d;
        @(posedge clk);
        #1;
        d_addr  = 64'h100;
        d_wdata = 64'h0000_0000_DEAD_BEEF;
        d_we    = 1'b1;
        d_req   = 1'b1;
        sb_q.push_back('{port: 1'b1, data: prev_d});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_n++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            if (d_done) begin
                done_n++;
                d_req = 1'b0;
                d_we  = 1'b0;
            end
        end
        n_tests++;
        if (we_n !== 1 || we_addr !== 64'h100 || we_data !== 64'h0000_0000_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_strobe: cycles=%0d addr=%h data=%h, required 1 100 deadbeef", we_n, we_addr, we_data);
        end
        n_tests++;
        if (done_n !== 1 || d_rdata !== prev_d) begin
            n_fail++;
            $display("FAIL store_done: pulses=%0d d_rdata=%h, required 1 and %h", done_n, d_rdata, prev_d);
        end
        // Read the stored word back through a load
        @(posedge clk);
        #1;
        d_req = 1'b1;
        expect_txn(1'b1, 64'h0000_0000_DEAD_BEEF);
        done_n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d_done) begin
                done_n++;
                d_req = 1'b0;
            end
        end
        n_tests++;
        if (done_n !== 1) begin
            n_fail++;
            $display("FAIL store_readback_done: pulses=%0d, required 1", done_n);
        end
    endtask

    task automatic test_round_robin();
        int   done_n;
        logic exp_own;
        done_n = 0;
        apply_reset();
        i_addr = 64'h80;
        d_addr = 64'hC0;
        d_we   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) expect_txn(1'b1, pat(64'hC0 + 64'(8 * (k / 2))));
            else            expect_txn(1'b0, pat(64'h80 + 64'(8 * (k / 2))));
        end
        i_req = 1'b1;
        d_req = 1'b1;
        for (int c = 0; c < 40 && done_n < 6; c++) begin
            @(negedge clk);
            if (i_done || d_done) begin
                exp_own = (done_n % 2 == 0);
                n_tests++;
                if (owner !== exp_own) begin
                    n_fail++;
                    $display("FAIL rr_owner txn%0d: owner=%b, required %b", done_n, owner, exp_own);
                end
                if (d_done) d_addr = d_addr + 64'd8;
                if (i_done) i_addr = i_addr + 64'd8;
                done_n++;
                if (done_n == 6) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        n_tests++;
        if (done_n !== 6) begin
            n_fail++;
            $display("FAIL rr_count: completions=%0d, required 6", done_n);
        end
    endtask

    task automatic test_reset_mid();
        int done_n;
        done_n = 0;
        apply_reset();
        d_addr = 64'h300;
        d_we   = 1'b0;
        d_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || owner !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_started: busy=%b owner=%b, required 1 1", busy, owner);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        d_req = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: busy=%b, required 0", busy);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || d_done !== 1'b0 || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL midrst_idle: busy=%b d_done=%b d_rdata=%h, required 0 0 0", busy, d_done, d_rdata);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        sb_q.delete();
        exp_d = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (d_done) done_n++;
        end
        n_tests++;
        if (done_n !== 0 || d_rdata !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after: d_done_pulses=%0d d_rdata=%h busy=%b, required 0 0 0", done_n, d_rdata, busy);
        end
    endtask

    task automatic test_lat1();
        logic [3:0] btrace;
        logic [3:0] dtrace;
        btrace = '0; dtrace = '0;
        apply_reset();
        l1_d_addr = 64'h140;
        l1_d_we   = 1'b0;
        l1_d_req  = 1'b1;
        @(posedge clk);
        #1 l1_d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            btrace[k] = l1_busy;
            dtrace[k] = l1_d_done;
        end
        n_tests++;
        if (btrace !== 4'b0011 || dtrace !== 4'b0010) begin
            n_fail++;
            $display("FAIL lat1_timing: busy=%b d_done=%b, required 0011 0010", btrace, dtrace);
        end
        n_tests++;
        if (l1_d_rdata !== pat(64'h140) || l1_owner !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1_data: d_rdata=%h owner=%b, required %h 1", l1_d_rdata, l1_owner, pat(64'h140));
        end
        n_tests++;
        if ({l1_i_done, l1_mem_we, l1_i_rdata, l1_mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL lat1_quiet: i_done=%b mem_we=%b i_rdata=%h mem_wdata=%h, required 0",
                     l1_i_done, l1_mem_we, l1_i_rdata, l1_mem_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_tie();
        test_store();
        test_round_robin();
        test_reset_mid();
        test_lat1();
        repeat (4) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d completions outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

endmodule
